// File: rtl/rx_fifo_arbiter.sv
// Arbitrates the 0.9 GHz / 2.4 GHz RX FIFOs onto one byte stream, serializing words MSB-first.
// Define RX_ARB_HEADER_EN to prefix each word with a {7'b1010010, ch} header byte.
module rx_fifo_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4
) (
  input  logic                  i_sys_clk,
  input  logic                  i_rst_b,
  input  logic [1:0]            i_ch_en,
  input  logic                  i_fifo_09_empty,
  output logic                  o_fifo_09_pull,
  input  logic [DATA_WIDTH-1:0] i_fifo_09_data,
  input  logic                  i_fifo_24_empty,
  output logic                  o_fifo_24_pull,
  input  logic [DATA_WIDTH-1:0] i_fifo_24_data,
  output logic [7:0]            o_byte,
  output logic                  o_byte_valid,
  input  logic                  i_byte_ready,
  output logic                  o_byte_ch,
  output logic                  o_byte_last,
  output logic                  o_busy
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int BC_W   = $clog2(BURST_LEN + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NBYTES - 1);
  localparam logic [BC_W-1:0]  BURST_MAX = BC_W'(BURST_LEN);

`ifdef RX_ARB_HEADER_EN
  typedef enum logic [2:0] {IDLE, PULL, CAPTURE, HEADER, SHIFT} state_t;
`else
  typedef enum logic [1:0] {IDLE, PULL, CAPTURE, SHIFT} state_t;
`endif

  state_t                       state;
  logic                         cur_ch;
  logic [BC_W-1:0]              burst_cnt;
  logic [DATA_WIDTH-1:0]        shreg;
  logic [IDX_W-1:0]             byte_idx;
  logic [1:0]                   pull_q;
  logic                         byte_valid, byte_last, busy;
  logic                         hdr_q;

  logic [1:0]                   elig;
  logic [1:0][DATA_WIDTH-1:0]   fifo_data;
  logic                         cur_elig, oth_elig, stay, sw, grant, grant_ch, accept;
  logic [BC_W-1:0]              burst_inc;

  assign elig         = i_ch_en & ~{i_fifo_24_empty, i_fifo_09_empty};
  assign fifo_data[0] = i_fifo_09_data;
  assign fifo_data[1] = i_fifo_24_data;

  // Stay while under the burst cap, or past it when the other side has nothing to send.
  assign cur_elig  = elig[cur_ch];
  assign oth_elig  = elig[~cur_ch];
  assign stay      = cur_elig && ((burst_cnt < BURST_MAX) || !oth_elig);
  assign sw        = !stay && oth_elig;
  assign grant     = stay || sw;
  assign grant_ch  = stay ? cur_ch : ~cur_ch;
  assign burst_inc = (burst_cnt == BURST_MAX) ? BURST_MAX : burst_cnt + BC_W'(1);
  assign accept    = byte_valid && i_byte_ready;

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state      <= IDLE;
      cur_ch     <= 1'b0;
      burst_cnt  <= '0;
      shreg      <= '0;
      byte_idx   <= '0;
      pull_q     <= '0;
      byte_valid <= 1'b0;
      byte_last  <= 1'b0;
      busy       <= 1'b0;
      hdr_q      <= 1'b0;
    end else begin
      pull_q <= '0;
      case (state)
        IDLE: if (grant) begin
          state     <= PULL;
          cur_ch    <= grant_ch;
          burst_cnt <= sw ? BC_W'(1) : burst_inc;
          pull_q    <= grant_ch ? 2'b10 : 2'b01;
          busy      <= 1'b1;
        end
        PULL: state <= CAPTURE;
        CAPTURE: begin
          shreg      <= fifo_data[cur_ch];
          byte_idx   <= '0;
          byte_valid <= 1'b1;
`ifdef RX_ARB_HEADER_EN
          state      <= HEADER;
          hdr_q      <= 1'b1;
          byte_last  <= 1'b0;
`else
          state      <= SHIFT;
          byte_last  <= (LAST_IDX == '0);
`endif
        end
`ifdef RX_ARB_HEADER_EN
        HEADER: if (accept) begin
          state     <= SHIFT;
          hdr_q     <= 1'b0;
          byte_last <= (LAST_IDX == '0);
        end
`endif
        SHIFT: if (accept) begin
          if (byte_idx == LAST_IDX) begin
            state      <= IDLE;
            byte_valid <= 1'b0;
            byte_last  <= 1'b0;
            busy       <= 1'b0;
          end else begin
            shreg     <= shreg << 8;
            byte_idx  <= byte_idx + IDX_W'(1);
            byte_last <= ((byte_idx + IDX_W'(1)) == LAST_IDX);
          end
        end
        default: begin
          state      <= IDLE;
          byte_valid <= 1'b0;
          byte_last  <= 1'b0;
          busy       <= 1'b0;
          hdr_q      <= 1'b0;
        end
      endcase
    end
  end

  assign o_fifo_09_pull = pull_q[0];
  assign o_fifo_24_pull = pull_q[1];
  assign o_byte         = hdr_q ? {7'b1010010, cur_ch} : shreg[DATA_WIDTH-1 -: 8];
  assign o_byte_valid   = byte_valid;
  assign o_byte_ch      = cur_ch;
  assign o_byte_last    = byte_last;
  assign o_busy         = busy;

endmodule

// File: tb/tb_rx_fifo_arbiter.sv
// Bench for rx_fifo_arbiter: FIFO models, per-channel byte scoreboard, pull-order log.
module tb_rx_fifo_arbiter;

  typedef struct packed { logic [7:0] b; logic last; } exp_t;

`ifdef RX_ARB_HEADER_EN
  localparam int BYTES_PER_WORD = 5;
`else
  localparam int BYTES_PER_WORD = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_b;
  logic [1:0]  ch_en;
  logic        e09 = 1'b1, e24 = 1'b1;
  logic [31:0] d09 = '0, d24 = '0;
  logic        ready;
  logic        pull09, pull24, byte_valid, byte_ch, byte_last, busy;
  logic [7:0]  byte_o;

  int total = 0, bad = 0, underflow = 0;
  logic [31:0] q09[$], q24[$];
  exp_t        exp09[$], exp24[$];
  bit          plog[$];

  always #5 clk = ~clk;

  rx_fifo_arbiter dut (
    .i_sys_clk(clk), .i_rst_b(rst_b), .i_ch_en(ch_en),
    .i_fifo_09_empty(e09), .o_fifo_09_pull(pull09), .i_fifo_09_data(d09),
    .i_fifo_24_empty(e24), .o_fifo_24_pull(pull24), .i_fifo_24_data(d24),
    .o_byte(byte_o), .o_byte_valid(byte_valid), .i_byte_ready(ready),
    .o_byte_ch(byte_ch), .o_byte_last(byte_last), .o_busy(busy)
  );

  // FIFO models: data registered on the pull edge, flags refreshed mid-cycle.
  always @(posedge clk) begin
    if (pull09) begin
      if (q09.size() == 0) underflow++;
      else d09 <= q09.pop_front();
    end
    if (pull24) begin
      if (q24.size() == 0) underflow++;
      else d24 <= q24.pop_front();
    end
  end
  always @(negedge clk) begin
    e09 <= (q09.size() == 0);
    e24 <= (q24.size() == 0);
  end

  // Monitor: pull log, both-pull check, byte scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_b) begin
      if (pull09) plog.push_back(1'b0);
      if (pull24) plog.push_back(1'b1);
      if (pull09 && pull24) begin
        total++; bad++;
        $display("FAIL both_pulls: 09=%0b 24=%0b, required at most one", pull09, pull24);
      end
      if (byte_valid && ready) begin
        total++;
        if ((byte_ch ? exp24.size() : exp09.size()) == 0) begin
          bad++;
          $display("FAIL sb_unexpected: ch=%0d byte=%h with nothing expected", byte_ch, byte_o);
        end else begin
          e = byte_ch ? exp24.pop_front() : exp09.pop_front();
          if ({byte_o, byte_last} !== {e.b, e.last}) begin
            bad++;
            $display("FAIL sb_byte ch%0d: got byte=%h last=%0b, required byte=%h last=%0b",
                     byte_ch, byte_o, byte_last, e.b, e.last);
          end
        end
      end
    end
  end

  task automatic push_word(input bit ch, input logic [31:0] d);
    exp_t e;
    if (ch) q24.push_back(d); else q09.push_back(d);
`ifdef RX_ARB_HEADER_EN
    e.b = {7'b1010010, ch}; e.last = 1'b0;
    if (ch) exp24.push_back(e); else exp09.push_back(e);
`endif
    for (int i = 0; i < 4; i++) begin
      e.b = d[31-8*i -: 8]; e.last = (i == 3);
      if (ch) exp24.push_back(e); else exp09.push_back(e);
    end
  endtask

  task automatic do_reset();
    rst_b = 1'b0; ch_en = 2'b00; ready = 1'b1;
    #1;
    q09.delete(); q24.delete(); exp09.delete(); exp24.delete(); plog.delete();
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;
  endtask

  task automatic drain(input logic [1:0] mask, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if ((!mask[0] || (q09.size() == 0 && exp09.size() == 0)) &&
          (!mask[1] || (q24.size() == 0 && exp24.size() == 0)) && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    rst_b = 1'b0; ready = 1'b1; ch_en = 2'b11;
    push_word(1'b0, 32'h01020304);
    push_word(1'b1, 32'h0A0B0C0D);
    repeat (3) @(negedge clk);
    total++;
    if ({pull09, pull24, byte_o, byte_valid, byte_ch, byte_last, busy} !== 14'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h, required 0",
               {pull09, pull24, byte_o, byte_valid, byte_ch, byte_last, busy});
    end
    @(posedge clk); #1 rst_b = 1'b1;
    @(negedge clk);
    total++;
    if ({pull09, pull24} !== 2'b00) begin
      bad++; $display("FAIL reset_release_early: pulls=%b, required 00", {pull09, pull24});
    end
    @(negedge clk);
    total++;
    if ({pull24, pull09} !== 2'b01) begin
      bad++; $display("FAIL reset_first_pull: {24,09}=%b, required 01", {pull24, pull09});
    end
    drain(2'b11, 100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL reset_drain: timeout, required both words sent"); end
  endtask

  task automatic test_single_word();
    bit ok;
    do_reset();
    push_word(1'b0, 32'h11223344);
    ch_en = 2'b01;
    drain(2'b01, 50, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_drain: timeout, required word sent"); end
    total++;
    if (plog.size() != 1 || plog[0] !== 1'b0) begin
      bad++; $display("FAIL single_pulls: got %0d pulls, required exactly one 09 pull", plog.size());
    end
  endtask

  task automatic test_fairness();
    bit ok, want;
    int n;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      push_word(1'b0, 32'h09000000 + i);
      push_word(1'b1, 32'h24000000 + i);
    end
    ch_en = 2'b11;
    n = 0;
    while (plog.size() < 12 && n < 200) begin @(negedge clk); n++; end
    total++;
    if (plog.size() < 12) begin
      bad++; $display("FAIL fair_timeout: got %0d pulls, required 12", plog.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        want = (i >= 4 && i < 8);
        total++;
        if (plog[i] !== want) begin
          bad++; $display("FAIL fair_seq[%0d]: got ch%0d, required ch%0d", i, plog[i], want);
        end
      end
    end
    drain(2'b11, 400, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL fair_drain: timeout, required all 24 words sent"); end

    do_reset();
    for (int i = 0; i < 3; i++) push_word(1'b0, 32'h90900000 + i);
    for (int i = 0; i < 6; i++) push_word(1'b1, 32'h42420000 + i);
    ch_en = 2'b10;
    drain(2'b10, 200, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL only24_drain: timeout, required 6 words sent"); end
    n = 0;
    foreach (plog[i]) if (plog[i]) n++;
    total++;
    if (plog.size() != 6 || n != 6) begin
      bad++; $display("FAIL only24_pulls: got %0d pulls (%0d on 24), required 6 on 24", plog.size(), n);
    end
  endtask

  task automatic test_backpressure();
    bit ok, found;
    do_reset();
    push_word(1'b0, 32'hA1B2C3D4);
    push_word(1'b0, 32'h55667788);
    ch_en = 2'b01;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (byte_valid && byte_o == 8'hA1) found = 1'b1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL bp_find_a1: timeout, required byte A1"); end
    @(posedge clk); #1 ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({byte_valid, byte_o, pull09} !== {1'b1, 8'hB2, 1'b0}) begin
        bad++; $display("FAIL bp_hold[%0d]: valid=%0b byte=%h pull=%0b, required 1 B2 0",
                        i, byte_valid, byte_o, pull09);
      end
    end
    @(posedge clk); #1 ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (byte_valid && byte_o == 8'hD4) found = 1'b1;
    end
    total++;
    if (!found || plog.size() != 1) begin
      bad++; $display("FAIL bp_no_early_pull: found_d4=%0b pulls=%0d, required 1 and 1", found, plog.size());
    end
    drain(2'b01, 50, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL bp_drain: timeout, required both words sent"); end
  endtask

  task automatic test_midop();
    bit found;
    do_reset();
    push_word(1'b0, 32'h12345678);
    push_word(1'b0, 32'h9ABCDEF0);
    ch_en = 2'b01;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (byte_valid) found = 1'b1;
    end
    @(posedge clk); #1 ch_en = 2'b00;
    repeat (30) @(negedge clk);
    total++;
    if (!found || exp09.size() != BYTES_PER_WORD || plog.size() != 1 || busy !== 1'b0) begin
      bad++; $display("FAIL en_clear: valid_seen=%0b left=%0d pulls=%0d busy=%0b, required 1 %0d 1 0",
                      found, exp09.size(), plog.size(), busy, BYTES_PER_WORD);
    end

    do_reset();
    push_word(1'b0, 32'hCAFEF00D);
    ch_en = 2'b01;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (byte_valid) found = 1'b1;
    end
    @(posedge clk); #2;
    total++;
    if (byte_valid !== 1'b1) begin
      bad++; $display("FAIL rst_mid_pre: valid=%0b, required 1", byte_valid);
    end
    rst_b = 1'b0;
    #1;
    total++;
    if ({byte_valid, busy, byte_o} !== 10'h0) begin
      bad++; $display("FAIL rst_mid_async: valid=%0b busy=%0b byte=%h, required 0 0 00",
                      byte_valid, busy, byte_o);
    end
    do_reset();
  endtask

  task automatic test_ch24_word();
    bit ok;
    do_reset();
    push_word(1'b1, 32'hDEADBEEF);
    ch_en = 2'b10;
    drain(2'b10, 50, ok);
    total++;
    if (!ok || plog.size() != 1 || plog[0] !== 1'b1) begin
      bad++; $display("FAIL ch24_word: done=%0b pulls=%0d, required 1 and one 24 pull", ok, plog.size());
    end
  endtask

  task automatic test_fifo_integrity();
    total++;
    if (underflow != 0) begin
      bad++; $display("FAIL fifo_underflow: got %0d pulls on empty FIFO, required 0", underflow);
    end
  endtask

  initial begin
    rst_b = 1'b0; ch_en = 2'b00; ready = 1'b1;
    test_reset();
    test_single_word();
    test_fairness();
    test_backpressure();
    test_midop();
    test_ch24_word();
    test_fifo_integrity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
